// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Parses framed load packets from the UART RX byte stream and writes the
//   payload into a 32-bit single-port memory through its s1 write interface.
//   Packet: SYNC, ADDR_L, ADDR_H, CNT_L, CNT_H, CNT*4 data bytes (LE words), CHK.
//   CHK is the 8-bit sum of the data bytes.
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   abort             : synchronous abort, FSM returns to IDLE next cycle
//   rx_data/valid/ready : byte stream handshake (transfer on valid & ready)
//   mem_*             : registered memory write port, active only in WR
//   busy              : FSM not in IDLE
//   done              : one-cycle pulse after a good checksum
//   err_code          : 0 none, 1 range, 2 checksum; cleared by the next SYNC
module uart_mem_loader #(
  parameter int          ADDR_W    = 15,
  parameter int          MEM_WORDS = 17408,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WR, S_CHK} state_t;

  state_t              state_q, state_d;
  logic                rdy_en_q;
  logic [1:0]          hdr_idx_q, hdr_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [15:0]         start_q, start_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [23:0]         word_q, word_d;
  logic [7:0]          sum_q, sum_d;
  logic [1:0]          err_q, err_d;
  logic                done_q, done_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;

  logic                accept;
  logic [15:0]         cnt_full;
  logic [16:0]         end_w;
  logic [15:0]         waddr;

  // rx_ready stays low through reset and rises on the first edge after release.
  assign rx_ready = rdy_en_q && (state_q != S_WR);
  assign accept   = rx_valid && rx_ready;

  assign cnt_full = {rx_data, cnt_q[7:0]};
  // 17-bit end address so start + cnt cannot wrap past the range check.
  assign end_w    = {1'b0, start_q} + {1'b0, cnt_full};
  assign waddr    = start_q + word_idx_q;

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    byte_idx_d = byte_idx_q;
    start_d    = start_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    sum_d      = sum_q;
    err_d      = err_q;
    done_d     = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) begin
          err_d      = 2'd0;
          sum_d      = 8'd0;
          hdr_idx_d  = 2'd0;
          byte_idx_d = 2'd0;
          word_idx_d = 16'd0;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd0: start_d[7:0]  = rx_data;
            2'd1: start_d[15:8] = rx_data;
            2'd2: cnt_d[7:0]    = rx_data;
            default: begin
              cnt_d[15:8] = rx_data;
              if (end_w > 17'(MEM_WORDS)) begin
                err_d   = 2'd1;
                state_d = S_IDLE;
              end else if (cnt_full == 16'd0) begin
                state_d = S_CHK;
              end else begin
                state_d = S_DATA;
              end
            end
          endcase
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d      = sum_q + rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Load the write port now so it is registered during WR.
            mem_wr_d   = 1'b1;
            mem_addr_d = ADDR_W'(waddr);
            mem_data_d = {rx_data, word_q};
            state_d    = S_WR;
          end else begin
            word_d = {rx_data, word_q[23:8]};
          end
        end
      end
      S_WR: begin
        word_idx_d = word_idx_q + 16'd1;
        if ((word_idx_q + 16'd1) == cnt_q) state_d = S_CHK;
        else                               state_d = S_DATA;
      end
      S_CHK: begin
        if (accept) begin
          if (rx_data == sum_q) done_d = 1'b1;
          else                  err_d  = 2'd2;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; a write already registered for WR still
    // goes out because the mem_* flops were loaded a cycle earlier.
    if (abort) begin
      state_d  = S_IDLE;
      err_d    = err_q;
      done_d   = 1'b0;
      mem_wr_d = 1'b0;
      mem_addr_d = '0;
      mem_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      hdr_idx_q  <= '0;
      byte_idx_q <= '0;
      start_q    <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      hdr_idx_q  <= hdr_idx_d;
      byte_idx_q <= byte_idx_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      done_q     <= done_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_write      = mem_wr_q;
  assign mem_chipselect = mem_wr_q;
  assign mem_byteenable = {4{mem_wr_q}};
  assign mem_address    = mem_addr_q;
  assign mem_writedata  = mem_data_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err_code       = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader: packet table plus hand sequences for
// reset, error clearing, abort and mid-packet reset.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        abort;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;

  uart_mem_loader #(.ADDR_W(15), .MEM_WORDS(17408), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .busy(busy), .done(done),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: logs writes and done pulses, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          rdy_low  = 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_addr.push_back(32'(mem_address));
      wr_data.push_back(mem_writedata);
      wr_cyc.push_back(cyc);
      check("wr_byteenable", 32'(mem_byteenable), 32'hF);
      check("wr_chipselect", 32'(mem_chipselect), 32'h1);
    end
    if (done) done_cnt++;
    if (reset_n && !rx_ready) rdy_low++;
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    rdy_low  = 0;
  endtask

  // Holds rx_valid high; bounded wait for rx_ready, transfer on the next posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'h1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    rx_valid = 1'b0;
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [159:0] b;      // first byte in the most significant used byte
    int           nw;
    logic [2:0][31:0] a;
    logic [2:0][31:0] d;
    logic [1:0]   err;
    int           dn;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0].name = "basic";  tbl[0].n = 14;
    tbl[0].b = 160'hA5_10_00_02_00_11_22_33_44_55_66_77_88_64;
    tbl[0].nw = 2; tbl[0].a[0] = 32'h10; tbl[0].d[0] = 32'h44332211;
    tbl[0].a[1] = 32'h11; tbl[0].d[1] = 32'h88776655; tbl[0].err = 2'd0; tbl[0].dn = 1;

    tbl[1].name = "badchk"; tbl[1].n = 14;
    tbl[1].b = 160'hA5_10_00_02_00_11_22_33_44_55_66_77_88_00;
    tbl[1].nw = 2; tbl[1].a[0] = 32'h10; tbl[1].d[0] = 32'h44332211;
    tbl[1].a[1] = 32'h11; tbl[1].d[1] = 32'h88776655; tbl[1].err = 2'd2; tbl[1].dn = 0;

    tbl[2].name = "range";  tbl[2].n = 5;
    tbl[2].b = 160'hA5_FF_43_02_00;
    tbl[2].nw = 0; tbl[2].err = 2'd1; tbl[2].dn = 0;

    tbl[3].name = "garbage_cnt0"; tbl[3].n = 9;
    tbl[3].b = 160'h00_FF_5A_A5_00_00_00_00_00;
    tbl[3].nw = 0; tbl[3].err = 2'd0; tbl[3].dn = 1;

    tbl[4].name = "three_words"; tbl[4].n = 18;
    tbl[4].b = 160'hA5_00_01_03_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_4E;
    tbl[4].nw = 3;
    tbl[4].a[0] = 32'h100; tbl[4].d[0] = 32'h04030201;
    tbl[4].a[1] = 32'h101; tbl[4].d[1] = 32'h08070605;
    tbl[4].a[2] = 32'h102; tbl[4].d[2] = 32'h0C0B0A09;
    tbl[4].err = 2'd0; tbl[4].dn = 1;

    tbl[5].name = "sync_in_data"; tbl[5].n = 10;
    tbl[5].b = 160'hA5_20_00_01_00_A5_A5_A5_A5_94;
    tbl[5].nw = 1; tbl[5].a[0] = 32'h20; tbl[5].d[0] = 32'hA5A5A5A5;
    tbl[5].err = 2'd0; tbl[5].dn = 1;

    tbl[6].name = "top_of_mem"; tbl[6].n = 14;
    tbl[6].b = 160'hA5_FE_43_02_00_01_02_03_04_05_06_07_08_24;
    tbl[6].nw = 2; tbl[6].a[0] = 32'h43FE; tbl[6].d[0] = 32'h04030201;
    tbl[6].a[1] = 32'h43FF; tbl[6].d[1] = 32'h08070605;
    tbl[6].err = 2'd0; tbl[6].dn = 1;

    tbl[7].name = "end_equal_depth"; tbl[7].n = 6;
    tbl[7].b = 160'hA5_00_44_00_00_00;
    tbl[7].nw = 0; tbl[7].err = 2'd0; tbl[7].dn = 1;

    reset_n  = 1'b0;
    abort    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_code), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_cs", 32'(mem_chipselect), 0);
    check("rst_mem_be", 32'(mem_byteenable), 0);
    check("rst_mem_addr", 32'(mem_address), 0);
    check("rst_mem_data", mem_writedata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_rx_ready", 32'(rx_ready), 1);

    // Packet table
    for (int t = 0; t < 8; t++) begin
      logic [159:0] bs;
      bs = tbl[t].b;
      clear_mon();
      for (int i = 0; i < tbl[t].n; i++)
        send_byte(bs[8*(tbl[t].n-1-i) +: 8]);
      idle(4);
      check({tbl[t].name, "_nwrites"}, 32'(wr_addr.size()), 32'(tbl[t].nw));
      for (int i = 0; i < tbl[t].nw && i < wr_addr.size(); i++) begin
        check({tbl[t].name, "_addr"}, wr_addr[i], tbl[t].a[i]);
        check({tbl[t].name, "_data"}, wr_data[i], tbl[t].d[i]);
        if (i > 0) check({tbl[t].name, "_wr_gap"}, 32'(wr_cyc[i] - wr_cyc[i-1]), 5);
      end
      check({tbl[t].name, "_err"}, 32'(err_code), 32'(tbl[t].err));
      check({tbl[t].name, "_done"}, 32'(done_cnt), 32'(tbl[t].dn));
      check({tbl[t].name, "_busy"}, 32'(busy), 0);
      check({tbl[t].name, "_rdy_low"}, 32'(rdy_low), 32'(tbl[t].nw));
    end

    // err_code held over garbage, cleared by SYNC; abort from HDR
    clear_mon();
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h43);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h00);
    idle(1);
    check("err_held", 32'(err_code), 1);
    send_byte(8'hA5);
    idle(0);
    check("sync_clears_err", 32'(err_code), 0);
    check("sync_busy", 32'(busy), 1);
    pulse_abort();
    check("abort_hdr_busy", 32'(busy), 0);

    // Abort after two data bytes; trailing bytes land in IDLE and are dropped
    clear_mon();
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    pulse_abort();
    check("abort_busy", 32'(busy), 0);
    send_byte(8'h33); send_byte(8'h44);
    idle(4);
    check("abort_nwrites", 32'(wr_addr.size()), 0);
    check("abort_err", 32'(err_code), 0);
    check("abort_done", 32'(done_cnt), 0);
    check("abort_idle", 32'(busy), 0);

    // Reset mid-DATA
    clear_mon();
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rx_ready", 32'(rx_ready), 0);
    check("midrst_mem_write", 32'(mem_write), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_rel_rx_ready", 32'(rx_ready), 0);
    @(negedge clk);
    check("midrst_rx_ready_after", 32'(rx_ready), 1);
    check("midrst_busy_after", 32'(busy), 0);
    check("midrst_err_after", 32'(err_code), 0);
    check("midrst_nwrites", 32'(wr_addr.size()), 0);

    // Loader still works after the mid-packet reset
    clear_mon();
    for (int i = 0; i < 14; i++) begin
      logic [159:0] bs;
      bs = tbl[0].b;
      send_byte(bs[8*(13-i) +: 8]);
    end
    idle(4);
    check("post_rst_nwrites", 32'(wr_addr.size()), 2);
    check("post_rst_done", 32'(done_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait is never satisfied.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
